axi_sram_arbiter: RTL and testbench
===================================

# axi_sram_arbiter

Bridges the core's two SRAM-like request ports (instruction fetch and data load/store) onto a single AXI master interface. Sits between the pipeline (whose stalls the control unit derives from `*_addr_ok` / `*_data_ok`) and the external AXI bus.
- Reads from both sides share one AR/R channel, with data having priority.
- Data stores use the AW/W/B channels.
- Each side has at most one transaction in flight, so responses always return in request order.

## Interface
Parameters: none.

Ports:
- aclk  in  1  clock, all state on rising edge
- aresetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request, held until inst_addr_ok
- inst_addr  in  32  fetch address, word aligned
- inst_addr_ok  out  1  fetch accepted this cycle
- inst_data_ok  out  1  fetch data valid this cycle
- inst_rdata  out  32  fetch data
- data_req  in  1  data request, held until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  0 byte, 1 half, 2 word
- data_addr  in  32  data address
- data_wdata  in  32  store data, lane-aligned to address
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data valid / store complete this cycle
- data_rdata  out  32  load data
- arid  out  4  0 = inst, 1 = data
- araddr  out  32  read address
- arsize  out  3  read size
- arvalid / arready  out / in  1  AR handshake
- rid  in  4  read response id
- rdata  in  32  read data
- rvalid / rready  in / out  1  R handshake
- awaddr  out  32  write address
- awsize  out  3  write size
- awvalid / awready  out / in  1  AW handshake
- wdata  out  32  write data
- wstrb  out  4  byte strobes
- wlast  out  1  constant 1
- wvalid / wready  out / in  1  W handshake
- bvalid / bready  in / out  1  B handshake
- Tie-offs are done at the top level, not here: arlen = awlen = 0, burst = INCR, lock/cache/prot = 0, awid = wid = 1. rresp, bresp and rlast are ignored.

## Operation
- **Read FSM (R_IDLE → R_AR → R_R → R_IDLE).**
  - R_AR drives arvalid from registered id/addr/size.
  - Leaves R_AR on arready.
  - R_R drives rready = 1 and leaves on rvalid.
- **Write FSM (W_IDLE → W_AW → W_B → W_IDLE).**
  - W_AW drives awvalid and wvalid independently.
  - Flags aw_done and w_done latch each handshake; either valid drops after its own handshake.
  - Leaves W_AW when both handshakes are done (including same cycle).
  - W_B drives bready = 1 and leaves on bvalid.
- **Flags.**
  - data_busy: set on data accept, cleared on data_data_ok.
- **Acceptance (combinational, same cycle as req).**
  - Data load: data_req && !data_wr && !data_busy && R_IDLE → data_addr_ok = 1; latch arid = 1, araddr = data_addr, arsize = data_size.
  - Data store: data_req && data_wr && !data_busy && W_IDLE → data_addr_ok = 1; latch awaddr, awsize = data_size, wdata, wstrb.
  - Inst: inst_req && R_IDLE && !(load accepted this cycle) → inst_addr_ok = 1; latch arid = 0, araddr = inst_addr, arsize = 2. Data loads win over inst.
  - An inst fetch may proceed on AR/R concurrently with a store on AW/W/B.
- **wstrb.**
  - size 0: 4'b0001 << addr[1:0]
  - size 1: 4'b0011 << {addr[1],1'b0}
  - size 2: 4'b1111
  - size 3: treated as size 2
- **Responses (combinational).**
  - Read handshake in R_R: inst_data_ok = (rid == 0), data_data_ok = (rid == 1).
  - inst_rdata = data_rdata = rdata.
  - Store completion: data_data_ok = bvalid in W_B.
  - A load completion and a store completion can never coincide (data_busy guarantees this).

## Timing
- **Reset values** (all outputs, asynchronous on aresetn low):
  - FSMs in IDLE; data_busy = 0.
  - All valid/ready and *_ok outputs 0.
  - Address, id, size, data and strobe registers 0.
- **Minimum read latency:** req/addr_ok in cycle 0, arvalid from cycle 1; with arready in cycle 1 and rvalid in cycle 2, data_ok is in cycle 2.
- **Minimum store latency:** accept in cycle 0; aw/w in cycle 1; bvalid in cycle 2 gives data_data_ok in cycle 2.
- **Accept-on-return:** an FSM returning to IDLE in cycle N can accept a new request in cycle N+1, not N.
- **Valid stability:** arvalid, awvalid and wvalid, with their payloads, stay stable until their handshake.
- **Requests while busy:** a req arriving while its FSM is busy sees addr_ok = 0 and the request is not registered.
- **Reset mid-transaction:** the in-flight transaction is abandoned; no *_ok is emitted for it.

## Test plan
- **Inst fetch:** inst_req at 0x1FC00000, arready = 1, rvalid one cycle later with rdata = 0x3C080001 → inst_addr_ok in cycle 0, arid = 0 / arsize = 2 in cycle 1, inst_data_ok with 0x3C080001 in cycle 2.
- **Simultaneous inst_req and data load at 0x80000004** → only data_addr_ok; arid = 1 first. inst_addr_ok comes the cycle after the data R handshake.
- **Byte store** to 0x80000003, wdata = 0xAB000000 → wstrb = 4'b1000, awsize = 0. awready is delayed 3 cycles while wready = 1: wvalid drops after 1 beat, awvalid holds. data_data_ok on bvalid.
- **Overlap:** a store in W_B plus an inst fetch → the fetch completes independently. A second data_req stays unaccepted until after the store's data_data_ok.
- **Half store** at 0x80000002 → wstrb = 4'b1100. Word load with rvalid stalled 5 cycles → rready held and data_data_ok exactly once.
- **Reset mid-transaction:** aresetn low while in R_R → all outputs return to 0 immediately. A new fetch after reset completes normally.

Source files
------------

// File: rtl/axi_sram_arbiter.sv
// axi_sram_arbiter: bridges the core's fetch and data SRAM-like ports onto
// one AXI master. Loads and fetches share AR/R (data loads win), stores use
// AW/W/B. Each side keeps at most one transaction in flight, so responses
// return in request order without any reorder tracking.
module axi_sram_arbiter (
  input  logic        aclk,
  input  logic        aresetn,
  // instruction fetch port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data load/store port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI read address / read data
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address / write data / write response
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_R    = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_B    = 2'd2
  } w_state_e;

  localparam logic [3:0] ID_INST = 4'd0;
  localparam logic [3:0] ID_DATA = 4'd1;

  // read side state
  r_state_e    r_state_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [2:0]  arsize_q;
  logic        arvalid_q;
  logic        rready_q;

  // write side state
  w_state_e    w_state_q;
  logic [31:0] awaddr_q;
  logic [2:0]  awsize_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic        bready_q;

  // data side has a load or store outstanding
  logic        data_busy_q;

  // combinational decode
  logic        load_acc;
  logic        store_acc;
  logic        inst_acc;
  logic        r_hs;
  logic        b_hs;
  logic        aw_hs;
  logic        w_hs;
  logic        aw_done_d;
  logic        w_done_d;
  logic [3:0]  wstrb_d;

  // Acceptance: data load beats fetch on the shared read channel; a store
  // only needs the write FSM, so a fetch can run alongside it.
  assign load_acc  = data_req && !data_wr && !data_busy_q && (r_state_q == R_IDLE);
  assign store_acc = data_req &&  data_wr && !data_busy_q && (w_state_q == W_IDLE);
  assign inst_acc  = inst_req && (r_state_q == R_IDLE) && !load_acc;

  assign r_hs  = (r_state_q == R_R) && rvalid;
  assign b_hs  = (w_state_q == W_B) && bvalid;
  assign aw_hs = awvalid_q && awready;
  assign w_hs  = wvalid_q && wready;

  // A handshake seen this cycle counts as done, so both finishing together
  // moves straight to W_B.
  assign aw_done_d = aw_done_q || aw_hs;
  assign w_done_d  = w_done_q  || w_hs;

  // Byte-lane strobes from size and low address bits; size 3 acts as word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wstrb_d = 4'b1111;
    case (data_size)
      2'd0:    wstrb_d = 4'b0001 << data_addr[1:0];
      2'd1:    wstrb_d = 4'b0011 << {data_addr[1], 1'b0};
      default: wstrb_d = 4'b1111;
    endcase
  end

  // Read FSM: latch the winning request, present AR, then wait for R.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      arid_q    <= '0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      case (r_state_q)
        R_IDLE: begin
          if (load_acc) begin
            arid_q    <= ID_DATA;
            araddr_q  <= data_addr;
            arsize_q  <= {1'b0, data_size};
            arvalid_q <= 1'b1;
            r_state_q <= R_AR;
          end else if (inst_acc) begin
            arid_q    <= ID_INST;
            araddr_q  <= inst_addr;
            arsize_q  <= 3'd2;
            arvalid_q <= 1'b1;
            r_state_q <= R_AR;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            r_state_q <= R_R;
          end
        end
        R_R: begin
          if (rvalid) begin
            rready_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          r_state_q <= R_IDLE;
        end
      endcase
    end
  end

  // Write FSM: AW and W handshake independently, then wait for B.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (store_acc) begin
            awaddr_q  <= data_addr;
            awsize_q  <= {1'b0, data_size};
            wdata_q   <= data_wdata;
            wstrb_q   <= wstrb_d;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            w_state_q <= W_AW;
          end
        end
        W_AW: begin
          if (aw_hs) awvalid_q <= 1'b0;
          if (w_hs)  wvalid_q  <= 1'b0;
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) begin
            bready_q  <= 1'b1;
            w_state_q <= W_B;
          end
        end
        W_B: begin
          if (bvalid) begin
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          w_state_q <= W_IDLE;
        end
      endcase
    end
  end

  // data_busy spans data accept to its completion; accept needs !busy and
  // completion needs busy, so the two never collide.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_busy_q <= 1'b0;
    end else if (data_addr_ok) begin
      data_busy_q <= 1'b1;
    end else if (data_data_ok) begin
      data_busy_q <= 1'b0;
    end
  end

  // pipeline-side handshakes
  assign inst_addr_ok = inst_acc;
  assign data_addr_ok = load_acc || store_acc;
  assign inst_data_ok = r_hs && (rid == ID_INST);
  assign data_data_ok = (r_hs && (rid == ID_DATA)) || b_hs;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  // AXI outputs straight from registers
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign awaddr  = awaddr_q;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule

// File: tb/tb_axi_sram_arbiter.sv
// Bench for axi_sram_arbiter: directed cycle-by-cycle stimulus with a
// scoreboard for inst/data completions and inline checks of the AXI side.
module tb_axi_sram_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready;

  typedef struct {
    bit          is_store;
    logic [31:0] rdata;
  } data_exp_t;

  logic [31:0] inst_q[$];
  data_exp_t   data_q[$];

  int n_checks = 0;
  int n_errors = 0;

  axi_sram_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // step to just after the next rising edge, where inputs are driven
  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  // sample point: falling edge, well away from the active edge
  task automatic mid();
    @(negedge aclk);
  endtask

  task automatic push_data(input bit is_store, input logic [31:0] d);
    data_exp_t e;
    e.is_store = is_store;
    e.rdata    = d;
    data_q.push_back(e);
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
  endtask

  // Scoreboard monitor: every completion pops the oldest expectation.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (inst_data_ok) begin
        if (inst_q.size() == 0) check("inst_ok_unexpected", {31'd0, inst_data_ok}, 0);
        else check("inst_rdata", inst_rdata, inst_q.pop_front());
      end
      if (data_data_ok) begin
        if (data_q.size() == 0) begin
          check("data_ok_unexpected", {31'd0, data_data_ok}, 0);
        end else begin
          data_exp_t e;
          e = data_q.pop_front();
          if (e.is_store) check("store_done_on_bvalid", {31'd0, bvalid}, 1);
          else            check("data_rdata", data_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    aresetn = 0;
    #2;
    // ---- reset state ----
    check("rst_arvalid", {31'd0, arvalid}, 0);
    check("rst_rready",  {31'd0, rready}, 0);
    check("rst_awvalid", {31'd0, awvalid}, 0);
    check("rst_wvalid",  {31'd0, wvalid}, 0);
    check("rst_bready",  {31'd0, bready}, 0);
    check("rst_araddr",  araddr, 0);
    check("rst_wstrb",   {28'd0, wstrb}, 0);
    check("rst_wlast",   {31'd0, wlast}, 1);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;

    // ---- inst fetch, minimum latency ----
    cyc(); inst_req = 1; inst_addr = 32'h1FC0_0000; arready = 1;
    inst_q.push_back(32'h3C08_0001);
    mid(); check("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 1);
    cyc(); inst_req = 0;
    mid(); check("t1_arvalid", {31'd0, arvalid}, 1);
           check("t1_arid", {28'd0, arid}, 0);
           check("t1_arsize", {29'd0, arsize}, 2);
           check("t1_araddr", araddr, 32'h1FC0_0000);
    cyc(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h3C08_0001;
    mid(); check("t1_rready", {31'd0, rready}, 1);
           check("t1_inst_data_ok", {31'd0, inst_data_ok}, 1);
    cyc(); idle_inputs();
    mid(); check("t1_arvalid_after", {31'd0, arvalid}, 0);

    // ---- simultaneous fetch and load: load wins ----
    cyc(); inst_req = 1; inst_addr = 32'h1FC0_0008;
           data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h8000_0004;
    push_data(0, 32'h1234_5678);
    mid(); check("t2_data_addr_ok", {31'd0, data_addr_ok}, 1);
           check("t2_inst_addr_ok0", {31'd0, inst_addr_ok}, 0);
    cyc(); data_req = 0; arready = 1;
    mid(); check("t2_arid", {28'd0, arid}, 1);
           check("t2_araddr", araddr, 32'h8000_0004);
           check("t2_inst_addr_ok1", {31'd0, inst_addr_ok}, 0);
    cyc(); arready = 0; rvalid = 1; rid = 1; rdata = 32'h1234_5678;
    mid(); check("t2_data_data_ok", {31'd0, data_data_ok}, 1);
           check("t2_inst_addr_ok2", {31'd0, inst_addr_ok}, 0);
    cyc(); rvalid = 0;
    inst_q.push_back(32'h0000_0013);
    mid(); check("t2_inst_addr_ok3", {31'd0, inst_addr_ok}, 1);
    cyc(); inst_req = 0; arready = 1;
    mid(); check("t2_arid_inst", {28'd0, arid}, 0);
           check("t2_araddr_inst", araddr, 32'h1FC0_0008);
    cyc(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h0000_0013;
    mid(); check("t2_inst_data_ok", {31'd0, inst_data_ok}, 1);
    cyc(); idle_inputs();

    // ---- byte store, AW delayed 3 cycles ----
    cyc(); data_req = 1; data_wr = 1; data_size = 0;
           data_addr = 32'h8000_0003; data_wdata = 32'hAB00_0000;
    push_data(1, 0);
    mid(); check("t3_data_addr_ok", {31'd0, data_addr_ok}, 1);
    cyc(); data_req = 0; wready = 1;
    mid(); check("t3_awvalid", {31'd0, awvalid}, 1);
           check("t3_wvalid", {31'd0, wvalid}, 1);
           check("t3_wstrb", {28'd0, wstrb}, 32'h8);
           check("t3_awsize", {29'd0, awsize}, 0);
           check("t3_awaddr", awaddr, 32'h8000_0003);
           check("t3_wdata", wdata, 32'hAB00_0000);
    cyc();
    mid(); check("t3_wvalid_drop", {31'd0, wvalid}, 0);
           check("t3_awvalid_hold1", {31'd0, awvalid}, 1);
    cyc();
    mid(); check("t3_awvalid_hold2", {31'd0, awvalid}, 1);
           check("t3_awaddr_hold", awaddr, 32'h8000_0003);
    cyc(); awready = 1;
    mid(); check("t3_awvalid_hold3", {31'd0, awvalid}, 1);
    cyc(); awready = 0; wready = 0;
    mid(); check("t3_awvalid_drop", {31'd0, awvalid}, 0);
           check("t3_bready", {31'd0, bready}, 1);
           check("t3_no_ok_yet", {31'd0, data_data_ok}, 0);
    cyc(); bvalid = 1;
    mid(); check("t3_data_data_ok", {31'd0, data_data_ok}, 1);
    cyc(); idle_inputs();

    // ---- store in W_B overlapped with a fetch; load held off ----
    cyc(); data_req = 1; data_wr = 1; data_size = 2;
           data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
    push_data(1, 0);
    mid(); check("t4_store_ok", {31'd0, data_addr_ok}, 1);
    cyc(); data_req = 0; awready = 1; wready = 1;
    mid(); check("t4_wstrb", {28'd0, wstrb}, 32'hF);
    cyc(); awready = 0; wready = 0;
           inst_req = 1; inst_addr = 32'h1FC0_0004;
           data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h8000_0020;
    inst_q.push_back(32'h2402_0001);
    mid(); check("t4_inst_addr_ok", {31'd0, inst_addr_ok}, 1);
           check("t4_load_blocked0", {31'd0, data_addr_ok}, 0);
    cyc(); inst_req = 0; arready = 1;
    mid(); check("t4_arid", {28'd0, arid}, 0);
           check("t4_load_blocked1", {31'd0, data_addr_ok}, 0);
    cyc(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h2402_0001;
    mid(); check("t4_inst_data_ok", {31'd0, inst_data_ok}, 1);
           check("t4_bready", {31'd0, bready}, 1);
           check("t4_load_blocked2", {31'd0, data_addr_ok}, 0);
    cyc(); rvalid = 0; bvalid = 1;
    mid(); check("t4_store_done", {31'd0, data_data_ok}, 1);
           check("t4_load_blocked3", {31'd0, data_addr_ok}, 0);
    cyc(); bvalid = 0;
    push_data(0, 32'hCAFE_F00D);
    mid(); check("t4_load_accepted", {31'd0, data_addr_ok}, 1);
    cyc(); data_req = 0; arready = 1;
    mid(); check("t4_arid_load", {28'd0, arid}, 1);
           check("t4_araddr_load", araddr, 32'h8000_0020);
    cyc(); arready = 0; rvalid = 1; rid = 1; rdata = 32'hCAFE_F00D;
    mid(); check("t4_load_done", {31'd0, data_data_ok}, 1);
    cyc(); idle_inputs();

    // ---- half store, then word load with a stalled R ----
    cyc(); data_req = 1; data_wr = 1; data_size = 1;
           data_addr = 32'h8000_0002; data_wdata = 32'h5566_0000;
    push_data(1, 0);
    mid(); check("t5_store_ok", {31'd0, data_addr_ok}, 1);
    cyc(); data_req = 0; awready = 1; wready = 1;
    mid(); check("t5_wstrb", {28'd0, wstrb}, 32'hC);
           check("t5_awsize", {29'd0, awsize}, 1);
    cyc(); awready = 0; wready = 0; bvalid = 1;
    mid(); check("t5_store_done", {31'd0, data_data_ok}, 1);
    cyc(); bvalid = 0;
           data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h8000_0008;
    push_data(0, 32'h0BAD_C0DE);
    mid(); check("t5_load_ok", {31'd0, data_addr_ok}, 1);
    cyc(); data_req = 0; arready = 1;
    mid(); check("t5_araddr", araddr, 32'h8000_0008);
    cyc(); arready = 0;
    for (int i = 0; i < 5; i++) begin
      mid(); check("t5_rready_held", {31'd0, rready}, 1);
             check("t5_no_early_ok", {31'd0, data_data_ok}, 0);
      cyc();
    end
    rvalid = 1; rid = 1; rdata = 32'h0BAD_C0DE;
    mid(); check("t5_load_done", {31'd0, data_data_ok}, 1);
    cyc(); rvalid = 0;
    mid(); check("t5_ok_once", {31'd0, data_data_ok}, 0);
           check("t5_rready_drop", {31'd0, rready}, 0);

    // ---- reset while in R_R ----
    cyc(); inst_req = 1; inst_addr = 32'h1FC0_0100;
    inst_q.push_back(32'h0);
    mid(); check("t6_inst_addr_ok", {31'd0, inst_addr_ok}, 1);
    cyc(); inst_req = 0; arready = 1;
    cyc(); arready = 0;
    mid(); check("t6_rready_pre", {31'd0, rready}, 1);
    cyc(); rvalid = 1; rid = 0; rdata = 32'h1111_1111;
           aresetn = 0;
    inst_q.delete();
    #1;
    check("t6_rst_rready", {31'd0, rready}, 0);
    check("t6_rst_arvalid", {31'd0, arvalid}, 0);
    check("t6_rst_inst_ok", {31'd0, inst_data_ok}, 0);
    check("t6_rst_data_ok", {31'd0, data_data_ok}, 0);
    check("t6_rst_arid", {28'd0, arid}, 0);
    check("t6_rst_araddr", araddr, 0);
    cyc(); rvalid = 0;
    cyc(); aresetn = 1;
    cyc(); inst_req = 1; inst_addr = 32'h1FC0_0200;
    inst_q.push_back(32'h2108_0004);
    mid(); check("t6_post_addr_ok", {31'd0, inst_addr_ok}, 1);
    cyc(); inst_req = 0; arready = 1;
    mid(); check("t6_post_araddr", araddr, 32'h1FC0_0200);
    cyc(); arready = 0; rvalid = 1; rid = 0; rdata = 32'h2108_0004;
    mid(); check("t6_post_data_ok", {31'd0, inst_data_ok}, 1);
    cyc(); idle_inputs();
    cyc();

    // every expected completion must have been consumed
    check("inst_q_drained", inst_q.size(), 0);
    check("data_q_drained", data_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
